// File: rtl/id_branch_stage_pkg.sv
// rtl/id_branch_stage_pkg.sv - bundle widths, reset PC and LoongArch branch opcodes
package id_branch_stage_pkg;

   localparam int          IF2ID_LEN = 64;
   localparam int          ID2EX_LEN = 128;
   localparam logic [31:0] RESET_PC  = 32'h1bfffffc;

   localparam logic [5:0] OP_JIRL = 6'h13;
   localparam logic [5:0] OP_B    = 6'h14;
   localparam logic [5:0] OP_BL   = 6'h15;
   localparam logic [5:0] OP_BEQ  = 6'h16;
   localparam logic [5:0] OP_BNE  = 6'h17;
   localparam logic [5:0] OP_BLT  = 6'h18;
   localparam logic [5:0] OP_BGE  = 6'h19;
   localparam logic [5:0] OP_BLTU = 6'h1a;
   localparam logic [5:0] OP_BGEU = 6'h1b;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } if2id_t;

   // Conditional branches compare rj against rd, so port 2 must read rd for them.
   function automatic logic is_cond_branch(input logic [5:0] op);
      return (op >= OP_BEQ) && (op <= OP_BGEU);
   endfunction

endpackage

// File: rtl/id_branch_stage_br_resolve.sv
// rtl/id_branch_stage_br_resolve.sv - combinational branch decode, condition and target
module br_resolve
   import id_branch_stage_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] inst,
   input  logic [31:0] rj_value,
   input  logic [31:0] rkd_value,
   output logic        is_branch,
   output logic        cond,
   output logic [31:0] target
);

   logic [5:0]  op;
   logic [31:0] off18;
   logic [31:0] off28;

   assign op    = inst[31:26];
   assign off18 = {{14{inst[25]}}, inst[25:10], 2'b00};
   assign off28 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};

   always_comb begin
      is_branch = 1'b1;
      cond      = 1'b0;
      target    = pc + off18;
      case (op)
         OP_JIRL: begin
            cond   = 1'b1;
            target = rj_value + off18;
         end
         OP_B, OP_BL: begin
            cond   = 1'b1;
            target = pc + off28;
         end
         OP_BEQ:  cond = (rj_value == rkd_value);
         OP_BNE:  cond = (rj_value != rkd_value);
         OP_BLT:  cond = ($signed(rj_value) <  $signed(rkd_value));
         OP_BGE:  cond = ($signed(rj_value) >= $signed(rkd_value));
         OP_BLTU: cond = (rj_value <  rkd_value);
         OP_BGEU: cond = (rj_value >= rkd_value);
         default: is_branch = 1'b0;
      endcase
   end

endmodule

// File: rtl/id_branch_stage.sv
// rtl/id_branch_stage.sv - ID pipeline register, operand read and branch resolution
module id_branch_stage
   import id_branch_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_to_id_valid,
   input  logic [IF2ID_LEN-1:0] if_to_id_zip,
   output logic                 id_allowin,
   output logic                 br_taken,
   output logic [31:0]          br_target,
   output logic [4:0]           rf_raddr1,
   output logic [4:0]           rf_raddr2,
   input  logic [31:0]          rf_rdata1,
   input  logic [31:0]          rf_rdata2,
   input  logic                 id_stall,
   input  logic                 ex_allowin,
   output logic                 id_to_ex_valid,
   output logic [ID2EX_LEN-1:0] id_to_ex_zip
);

   logic        id_valid_q, id_valid_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_ready_go;
   logic        is_branch;
   logic        cond;
   if2id_t      fetch;

   assign fetch          = if_to_id_zip;
   assign id_ready_go    = ~id_stall;
   assign id_allowin     = ~id_valid_q | (id_ready_go & ex_allowin);
   assign id_to_ex_valid = id_valid_q & id_ready_go;

   assign rf_raddr1 = id_inst_q[9:5];
   assign rf_raddr2 = is_cond_branch(id_inst_q[31:26]) ? id_inst_q[4:0] : id_inst_q[14:10];

   br_resolve u_br_resolve (
      .pc        (id_pc_q),
      .inst      (id_inst_q),
      .rj_value  (rf_rdata1),
      .rkd_value (rf_rdata2),
      .is_branch (is_branch),
      .cond      (cond),
      .target    (br_target)
   );

   assign br_taken     = id_valid_q & id_ready_go & is_branch & cond;
   assign id_to_ex_zip = {id_pc_q, id_inst_q, rf_rdata1, rf_rdata2};

   // The fetch arriving alongside a taken branch is the wrong-path slot: kept but marked invalid.
   always_comb begin
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      if (id_allowin) begin
         id_valid_d = if_to_id_valid & ~br_taken;
         if (if_to_id_valid) begin
            id_pc_d   = fetch.pc;
            id_inst_d = fetch.inst;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         id_valid_q <= 1'b0;
         id_pc_q    <= RESET_PC;
         id_inst_q  <= 32'h0;
      end else begin
         id_valid_q <= id_valid_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
      end
   end

endmodule

// File: tb/tb_id_branch_stage.sv
// tb/tb_id_branch_stage.sv - directed self-checking bench for id_branch_stage
module tb_id_branch_stage;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_to_id_valid;
   logic [63:0]   if_to_id_zip;
   logic          id_allowin;
   logic          br_taken;
   logic [31:0]   br_target;
   logic [4:0]    rf_raddr1;
   logic [4:0]    rf_raddr2;
   logic [31:0]   rf_rdata1;
   logic [31:0]   rf_rdata2;
   logic          id_stall;
   logic          ex_allowin;
   logic          id_to_ex_valid;
   logic [127:0]  id_to_ex_zip;

   logic [31:0]   regs [32];
   int            checks = 0;
   int            failures = 0;

   localparam logic [31:0] I_BEQ  = 32'h58001085;
   localparam logic [31:0] I_BL   = 32'h57fffbff;
   localparam logic [31:0] I_BLT  = 32'h600008c7;
   localparam logic [31:0] I_BLTU = 32'h680008c7;
   localparam logic [31:0] I_JIRL = 32'h4c000020;
   localparam logic [31:0] I_B4   = 32'h50000400;
   localparam logic [31:0] I_NOP  = 32'h02800000;

   always #5 clk = ~clk;

   assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'h0 : regs[rf_raddr1];
   assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'h0 : regs[rf_raddr2];

   id_branch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .if_to_id_valid (if_to_id_valid),
      .if_to_id_zip   (if_to_id_zip),
      .id_allowin     (id_allowin),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .rf_raddr1      (rf_raddr1),
      .rf_raddr2      (rf_raddr2),
      .rf_rdata1      (rf_rdata1),
      .rf_rdata2      (rf_rdata2),
      .id_stall       (id_stall),
      .ex_allowin     (ex_allowin),
      .id_to_ex_valid (id_to_ex_valid),
      .id_to_ex_zip   (id_to_ex_zip)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
      if_to_id_valid = v;
      if_to_id_zip   = {inst, pc};
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h0;
      reset = 1'b1; ex_allowin = 1'b1; id_stall = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_allowin", {31'b0, id_allowin}, 32'd1);
      check("rst_to_ex_valid", {31'b0, id_to_ex_valid}, 32'd0);
      check("rst_br_taken", {31'b0, br_taken}, 32'd0);
      check("rst_pc", id_to_ex_zip[127:96], 32'h1bfffffc);

      // beq taken, wrong-path pc+4 squashed
      regs[4] = 32'd5; regs[5] = 32'd5;
      drive(1'b1, I_BEQ, 32'h1c000000); tick();
      drive(1'b1, I_NOP, 32'h1c000004); #1;
      check("beq_taken", {31'b0, br_taken}, 32'd1);
      check("beq_target", br_target, 32'h1c000010);
      check("beq_to_ex", {31'b0, id_to_ex_valid}, 32'd1);
      check("beq_rj", id_to_ex_zip[63:32], 32'd5);
      tick();
      drive(1'b0, I_NOP, 32'h0); #1;
      check("squash_valid", {31'b0, id_to_ex_valid}, 32'd0);
      check("squash_pc", id_to_ex_zip[127:96], 32'h1c000004);
      check("squash_br", {31'b0, br_taken}, 32'd0);
      tick();

      // beq not taken, fall-through proceeds
      regs[5] = 32'd6;
      drive(1'b1, I_BEQ, 32'h1c000000); tick();
      drive(1'b1, I_NOP, 32'h1c000004); #1;
      check("beq_nt", {31'b0, br_taken}, 32'd0);
      check("beq_raddr2", {27'b0, rf_raddr2}, 32'd5);
      tick();
      drive(1'b0, I_NOP, 32'h0); #1;
      check("fall_valid", {31'b0, id_to_ex_valid}, 32'd1);
      check("fall_pc", id_to_ex_zip[127:96], 32'h1c000004);
      tick();

      // blt signed taken vs bltu unsigned not taken
      regs[6] = 32'hffffffff; regs[7] = 32'd1;
      drive(1'b1, I_BLT, 32'h1c000020); tick();
      drive(1'b0, I_NOP, 32'h0); #1;
      check("blt_taken", {31'b0, br_taken}, 32'd1);
      check("blt_target", br_target, 32'h1c000028);
      tick();
      drive(1'b1, I_BLTU, 32'h1c000040); tick();
      drive(1'b0, I_NOP, 32'h0); #1;
      check("bltu_nt", {31'b0, br_taken}, 32'd0);
      check("bltu_raddr2", {27'b0, rf_raddr2}, 32'd7);
      tick();

      // bl backward
      drive(1'b1, I_BL, 32'h1c000100); tick();
      drive(1'b0, I_NOP, 32'h0); #1;
      check("bl_taken", {31'b0, br_taken}, 32'd1);
      check("bl_target", br_target, 32'h1c0000f8);
      tick();

      // jirl held by ex_allowin=0 for 3 cycles
      regs[1] = 32'h1c000ab0;
      ex_allowin = 1'b0;
      drive(1'b1, I_JIRL, 32'h1c000200); tick();
      drive(1'b1, I_NOP, 32'h1c000204);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("hold_taken", {31'b0, br_taken}, 32'd1);
         check("hold_allowin", {31'b0, id_allowin}, 32'd0);
         check("hold_target", br_target, 32'h1c000ab0);
         check("hold_pc", id_to_ex_zip[127:96], 32'h1c000200);
         tick();
      end
      ex_allowin = 1'b1; #1;
      check("rel_taken", {31'b0, br_taken}, 32'd1);
      check("rel_allowin", {31'b0, id_allowin}, 32'd1);
      tick();
      drive(1'b1, I_NOP, 32'h1c000ab0); #1;
      check("rel_squash", {31'b0, id_to_ex_valid}, 32'd0);
      check("rel_br", {31'b0, br_taken}, 32'd0);
      tick();
      drive(1'b0, I_NOP, 32'h0); #1;
      check("rel_target_valid", {31'b0, id_to_ex_valid}, 32'd1);
      check("rel_target_pc", id_to_ex_zip[127:96], 32'h1c000ab0);
      tick();

      // stall suppresses redirect and holds the bundle
      drive(1'b1, I_B4, 32'h1c000300); tick();
      id_stall = 1'b1;
      drive(1'b1, I_NOP, 32'h1c000304); #1;
      check("stall_br", {31'b0, br_taken}, 32'd0);
      check("stall_allowin", {31'b0, id_allowin}, 32'd0);
      check("stall_to_ex", {31'b0, id_to_ex_valid}, 32'd0);
      tick();
      id_stall = 1'b0; #1;
      check("unstall_br", {31'b0, br_taken}, 32'd1);
      check("unstall_target", br_target, 32'h1c000304);
      check("unstall_pc", id_to_ex_zip[127:96], 32'h1c000300);
      tick();
      drive(1'b0, I_NOP, 32'h0); #1;
      check("unstall_squash", {31'b0, id_to_ex_valid}, 32'd0);
      tick();

      // back-to-back branches: second is on the wrong path
      drive(1'b1, I_B4, 32'h1c000400); tick();
      drive(1'b1, I_B4, 32'h1c000404); #1;
      check("b2b_first", {31'b0, br_taken}, 32'd1);
      tick();
      drive(1'b0, I_NOP, 32'h0); #1;
      check("b2b_second", {31'b0, br_taken}, 32'd0);
      check("b2b_to_ex", {31'b0, id_to_ex_valid}, 32'd0);
      tick();

      // reset with a pending branch
      drive(1'b1, I_B4, 32'h1c000500); tick();
      drive(1'b0, I_NOP, 32'h0);
      reset = 1'b1; tick();
      reset = 1'b0; #1;
      check("mid_rst_br", {31'b0, br_taken}, 32'd0);
      check("mid_rst_valid", {31'b0, id_to_ex_valid}, 32'd0);
      check("mid_rst_pc", id_to_ex_zip[127:96], 32'h1bfffffc);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
